// File: rtl/pmodi2s_tx.sv
// Mono I2S transmitter for the PmodI2S (CS4344): converts 12-bit offset-binary samples to 24-bit
// two's complement with gain and saturation, buffers one sample and sends it on both channels.
module pmodi2s_tx #(
    parameter int GAIN_SHIFT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] in_data,
    input  logic        in_wr,
    output logic        mclk,
    output logic        lrck,
    output logic        sclk,
    output logic        sdin,
    output logic        underrun,
    output logic        overrun
);

    localparam int SHIFT = 12 + GAIN_SHIFT;
    localparam logic signed [35:0] SAT_MAX = 36'sh0007FFFFF;
    localparam logic signed [35:0] SAT_MIN = -36'sh000800000;

    logic [10:0] cnt_q;
    logic [23:0] pend_q;
    logic        pend_v_q;
    logic [23:0] act_q;
    logic [23:0] act_d;
    logic [31:0] shr_q;
    logic        underrun_q;
    logic        overrun_q;

    logic signed [35:0] s12_ext;
    logic signed [35:0] s36;
    logic [23:0]        s24;
    logic               frame_end;
    logic               half_end;
    logic               shift_tick;

    assign frame_end  = (cnt_q == 11'h7FF);
    assign half_end   = (cnt_q[9:0] == 10'h3FF);
    assign shift_tick = (cnt_q[4:0] == 5'h1F);

    // Flipping the MSB turns offset binary into two's complement.
    always_comb begin
        s12_ext = {{24{~in_data[11]}}, ~in_data[11], in_data[10:0]};
        s36     = s12_ext <<< SHIFT;
        if (s36 > SAT_MAX) begin
            s24 = 24'h7FFFFF;
        end else if (s36 < SAT_MIN) begin
            s24 = 24'h800000;
        end else begin
            s24 = s36[23:0];
        end
    end

    // NOTE: every signal written in always_comb gets a default first, so no path can leave it
    // holding its old value and infer a latch.
    always_comb begin
        act_d = act_q;
        if (frame_end) begin
            if (in_wr) begin
                act_d = s24;
            end else if (pend_v_q) begin
                act_d = pend_q;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            pend_q     <= '0;
            pend_v_q   <= 1'b0;
            act_q      <= '0;
            shr_q      <= '0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_q + 11'd1;
            act_q      <= act_d;
            underrun_q <= frame_end && !in_wr && !pend_v_q;
            overrun_q  <= in_wr && pend_v_q;

            // A write landing on the frame load goes straight to act and never occupies the buffer.
            if (frame_end) begin
                pend_v_q <= 1'b0;
            end else if (in_wr) begin
                pend_q   <= s24;
                pend_v_q <= 1'b1;
            end

            // Loading act_d keeps left and right identical even when act changes on this edge.
            if (half_end) begin
                shr_q <= {1'b0, act_d, 7'b0};
            end else if (shift_tick) begin
                shr_q <= {shr_q[30:0], 1'b0};
            end
        end
    end

    assign mclk     = cnt_q[1];
    assign sclk     = cnt_q[4];
    assign lrck     = cnt_q[10];
    assign sdin     = shr_q[31];
    assign underrun = underrun_q;
    assign overrun  = overrun_q;

endmodule
